// File: rtl/wb_mem_responder.sv
// Wishbone classic slave in front of a one-cycle-latency SRAM macro.
// Define WB_RESP_ERR_EN to add wb_err_o and out-of-range address checking.
module wb_mem_responder #(
    parameter int VIRTUAL_ADDR_LEN = 32,
    parameter int WB_DATA_LEN      = 32,
    parameter int MEM_ADDR_LEN     = 8,
    parameter int WAIT_CYCLES      = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_we_i,
    input  logic [VIRTUAL_ADDR_LEN-1:0] wb_adr_i,
    input  logic [WB_DATA_LEN-1:0]      wb_dat_i,
    input  logic [3:0]                  wb_sel_i,
    output logic                        wb_ack_o,
    output logic [WB_DATA_LEN-1:0]      wb_dat_o,
`ifdef WB_RESP_ERR_EN
    output logic                        wb_err_o,
`endif
    output logic                        mem_csb_o,
    output logic                        mem_web_o,
    output logic [3:0]                  mem_wmask_o,
    output logic [MEM_ADDR_LEN-1:0]     mem_addr_o,
    output logic [31:0]                 mem_din_o,
    input  logic [31:0]                 mem_dout_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] rd_q;
    logic        we_q;
    logic        err_q;

    logic        accept;
    logic        adr_hi;
    logic        bad;
    logic        go;
    logic        resp_now;
    logic [31:0] resp_data;
    logic        unused_adr;

    assign accept = rstn && (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign adr_hi = |(wb_adr_i >> (MEM_ADDR_LEN + 2));
    assign unused_adr = ^wb_adr_i[1:0] ^ adr_hi;

`ifdef WB_RESP_ERR_EN
    assign bad = adr_hi;
`else
    assign bad = 1'b0;
`endif

    // The SRAM sees the request combinationally in the accept cycle only.
    assign go          = accept && !bad;
    assign mem_csb_o   = !go;
    assign mem_web_o   = !(go && wb_we_i);
    assign mem_wmask_o = (go && wb_we_i) ? wb_sel_i : 4'b0;
    assign mem_addr_o  = go ? wb_adr_i[MEM_ADDR_LEN+1:2] : '0;
    assign mem_din_o   = (go && wb_we_i) ? wb_dat_i : 32'd0;

    always_comb begin
        resp_now  = 1'b0;
        resp_data = rd_q;
        if (wb_cyc_i) begin
            if (state == ACCESS && WAIT_CYCLES == 0) begin
                resp_now = 1'b1;
                if (!we_q && !err_q)
                    resp_data = mem_dout_i;
            end else if (state == WAIT && cnt == 4'd0) begin
                resp_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_q     <= 32'd0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef WB_RESP_ERR_EN
            wb_err_o <= 1'b0;
`endif
        end else begin
            wb_ack_o <= resp_now && !err_q;
            wb_dat_o <= (resp_now && !err_q) ? resp_data : '0;
`ifdef WB_RESP_ERR_EN
            wb_err_o <= resp_now && err_q;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q  <= wb_we_i;
                        err_q <= bad;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        if (!we_q && !err_q)
                            rd_q <= mem_dout_i;
                        if (WAIT_CYCLES > 0) begin
                            cnt   <= WAIT_LOAD;
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i)
                        state <= IDLE;
                    else if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (0 and 3 wait states)
// with behavioural SRAMs and a queue-based response scoreboard.
module tb_wb_mem_responder;

    typedef struct {
        int          d;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        cyc[2], stb[2], we[2];
    logic [31:0] adr[2], dat[2];
    logic [3:0]  sel[2];
    logic        ack[2];
    logic [31:0] dato[2];
    logic        csb[2], web[2];
    logic [3:0]  wmask[2];
    logic [7:0]  maddr[2];
    logic [31:0] din[2], dout[2];
`ifdef WB_RESP_ERR_EN
    logic        err[2];
`endif

    logic [31:0] mem[2][256];
    logic [31:0] mdl[2][256];
    logic [31:0] lastrd[2];
    int          acc[2] = '{0, 0};
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    wb_mem_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rstn(rstn),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(dat[0]), .wb_sel_i(sel[0]),
        .wb_ack_o(ack[0]), .wb_dat_o(dato[0]),
`ifdef WB_RESP_ERR_EN
        .wb_err_o(err[0]),
`endif
        .mem_csb_o(csb[0]), .mem_web_o(web[0]), .mem_wmask_o(wmask[0]),
        .mem_addr_o(maddr[0]), .mem_din_o(din[0]), .mem_dout_i(dout[0])
    );

    wb_mem_responder #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .rstn(rstn),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(dat[1]), .wb_sel_i(sel[1]),
        .wb_ack_o(ack[1]), .wb_dat_o(dato[1]),
`ifdef WB_RESP_ERR_EN
        .wb_err_o(err[1]),
`endif
        .mem_csb_o(csb[1]), .mem_web_o(web[1]), .mem_wmask_o(wmask[1]),
        .mem_addr_o(maddr[1]), .mem_din_o(din[1]), .mem_dout_i(dout[1])
    );

    // Behavioural SRAM: read data valid the cycle after select.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (csb[d] === 1'b0) begin
                automatic logic [31:0] wv = mem[d][maddr[d]];
                acc[d] <= acc[d] + 1;
                if (web[d] === 1'b0) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[d][b])
                            wv[8*b +: 8] = din[d][8*b +: 8];
                    mem[d][maddr[d]] <= wv;
                end
                dout[d] <= mem[d][maddr[d]];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic idle_bus();
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0;
            adr[d] = 0; dat[d] = 0; sel[d] = 0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that
    // follows the ack cycle.
    task automatic beat(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input bit keep, input string nm);
        exp_t e;
        int   n;
        int   a0;
        logic [7:0] wi;
        wi = a[9:2];
        if (w) begin
            mdl[d][wi] = merge(mdl[d][wi], wd, s);
        end else begin
            lastrd[d] = mdl[d][wi];
        end
        e.d = d;
        e.data = lastrd[d];
        e.lat = (d == 0) ? 1 : 4;
        sb.push_back(e);
        cyc[d] = 1; stb[d] = 1; we[d] = w;
        adr[d] = a; dat[d] = wd; sel[d] = s;
        #1;
        total++;
        if (csb[d] !== 1'b0) begin
            bad++;
            $display("FAIL %s accept_csb: got %b want 0", nm, csb[d]);
        end
        a0 = acc[d];
        @(posedge clk); #1;
        if (!keep) stb[d] = 0;
        n = 0;
        while (ack[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        total++;
        if (n != e.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat);
        end
        total++;
        if (dato[d] !== e.data) begin
            bad++;
            $display("FAIL %s data: got %h want %h", nm, dato[d], e.data);
        end
        total++;
        if (csb[d] !== 1'b1 || acc[d] - a0 != 1) begin
            bad++;
            $display("FAIL %s sram_access: csb %b accesses %0d want 1 1",
                     nm, csb[d], acc[d] - a0);
        end
        @(posedge clk); #1;
        total++;
        if (ack[d] !== 1'b0 || dato[d] !== 32'd0) begin
            bad++;
            $display("FAIL %s ack_pulse: ack %b dat %h want 0 0",
                     nm, ack[d], dato[d]);
        end
        if (!keep) cyc[d] = 0;
    endtask

    task automatic quiet(input int d, input int cycles, input string nm);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ack[d] !== 1'b0 || dato[d] !== 32'd0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL %s no_ack: got %0d ack cycles want 0", nm, hits);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        idle_bus();
        cyc[0] = 1; stb[0] = 1; we[0] = 1;
        adr[0] = 32'h10; dat[0] = 32'hFFFF_FFFF; sel[0] = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (ack[d] !== 0 || dato[d] !== 0 || csb[d] !== 1 ||
                web[d] !== 1 || wmask[d] !== 0 || maddr[d] !== 0 ||
                din[d] !== 0) begin
                bad++;
                $display("FAIL reset_out%0d: ack %b dat %h csb %b web %b msk %h adr %h din %h want 0 0 1 1 0 0 0",
                         d, ack[d], dato[d], csb[d], web[d], wmask[d],
                         maddr[d], din[d]);
            end
`ifdef WB_RESP_ERR_EN
            total++;
            if (err[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_err%0d: got %b want 0", d, err[d]);
            end
`endif
        end
        idle_bus();
        rstn = 1;
        lastrd[0] = 0;
        lastrd[1] = 0;
        @(posedge clk); #1;
        total++;
        if (csb[0] !== 1 || ack[0] !== 0) begin
            bad++;
            $display("FAIL post_reset: csb %b ack %b want 1 0", csb[0], ack[0]);
        end
    endtask

    task automatic test_basic();
        beat(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "wr10");
        beat(0, 0, 32'h10, 32'h0, 4'h0, 0, "rd10");
        total++;
        if (lastrd[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rd10_model: got %h want deadbeef", lastrd[0]);
        end
    endtask

    task automatic test_mask();
        beat(0, 1, 32'h20, 32'h1122_3344, 4'hF, 0, "wr20");
        beat(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0011, 0, "wr20m");
        beat(0, 0, 32'h20, 32'h0, 4'h0, 0, "rd20");
        total++;
        if (lastrd[0] !== 32'h1122_CCDD) begin
            bad++;
            $display("FAIL rd20_mask: got %h want 1122ccdd", lastrd[0]);
        end
    endtask

    task automatic test_back_to_back();
        beat(0, 1, 32'h08, 32'h0000_0A02, 4'hF, 0, "wr08");
        beat(0, 1, 32'h0C, 32'h0000_0B03, 4'hF, 0, "wr0c");
        beat(0, 0, 32'h08, 32'h0, 4'h0, 0, "refill_a0");
        beat(0, 0, 32'h0C, 32'h0, 4'h0, 0, "refill_a1");
        beat(0, 0, 32'h08, 32'h0, 4'h0, 1, "refill_b0");
        beat(0, 0, 32'h0C, 32'h0, 4'h0, 0, "refill_b1");
`ifndef WB_RESP_ERR_EN
        beat(0, 0, 32'h1000_0008, 32'h0, 4'h0, 0, "alias08");
`endif
    endtask

    task automatic test_wait();
        beat(1, 1, 32'h40, 32'hCAFE_F00D, 4'hF, 0, "w3_wr40");
        beat(1, 0, 32'h40, 32'h0, 4'h0, 0, "w3_rd40");
    endtask

    task automatic test_abort();
        cyc[1] = 1; stb[1] = 1; we[1] = 1;
        adr[1] = 32'h50; dat[1] = 32'h5555_AAAA; sel[1] = 4'hF;
        mdl[1][8'h14] = 32'h5555_AAAA;
        @(posedge clk); #1;
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        quiet(1, 8, "abort_access");
        beat(1, 0, 32'h50, 32'h0, 4'h0, 0, "after_abort");
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        cyc[1] = 0; stb[1] = 0;
        lastrd[0] = 0;
        lastrd[1] = 0;
        quiet(1, 8, "reset_wait");
        beat(1, 0, 32'h40, 32'h0, 4'h0, 0, "after_reset1");
        beat(0, 0, 32'h10, 32'h0, 4'h0, 0, "after_reset0");
    endtask

`ifdef WB_RESP_ERR_EN
    task automatic test_err();
        int n;
        int a0;
        a0 = acc[0];
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h400;
        #1;
        total++;
        if (csb[0] !== 1'b1) begin
            bad++;
            $display("FAIL err_csb: got %b want 1", csb[0]);
        end
        @(posedge clk); #1;
        stb[0] = 0;
        n = 0;
        while (err[0] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 1 || ack[0] !== 1'b0 || acc[0] != a0) begin
            bad++;
            $display("FAIL err_pulse: lat %0d ack %b acc %0d want 1 0 0",
                     n, ack[0], acc[0] - a0);
        end
        @(posedge clk); #1;
        cyc[0] = 0;
        total++;
        if (err[0] !== 1'b0) begin
            bad++;
            $display("FAIL err_len: got %b want 0", err[0]);
        end
        beat(0, 0, 32'h10, 32'h0, 4'h0, 0, "after_err");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_back_to_back();
        test_wait();
        test_abort();
`ifdef WB_RESP_ERR_EN
        test_err();
`endif
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
